// File: rtl/line_fill_responder.sv
// Memory-side line-fill responder: one request at a time, programmable miss
// latency, returns the addressed line plus the next one, or commits a full-line write.
module line_fill_responder #(
  parameter int BLOCK_W  = 256,
  parameter int OFF_BITS = 5,
  parameter int IDX_BITS = 6,
  parameter int MISS_LAT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [31:0]        req_addr,
  input  logic               req_write,
  input  logic [BLOCK_W-1:0] req_wdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [BLOCK_W-1:0] resp_data0,
  output logic [BLOCK_W-1:0] resp_data1,
  output logic               resp_write,
  output logic               busy
);

  localparam int DEPTH = 2 ** IDX_BITS;
  localparam int IDX_LO = OFF_BITS;
  localparam int IDX_HI = OFF_BITS + IDX_BITS - 1;
  localparam logic [7:0] LAT_INIT = 8'(MISS_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [IDX_BITS-1:0]  idx_q, idx_d;
  logic                 wr_q, wr_d;
  logic [BLOCK_W-1:0]   wdata_q, wdata_d;
  logic [BLOCK_W-1:0]   rdata0_q, rdata0_d;
  logic [BLOCK_W-1:0]   rdata1_q, rdata1_d;
  logic                 rwrite_q, rwrite_d;

  logic [IDX_BITS-1:0]  idx_next;
  logic                 do_access;
  logic                 addr_unused;

  logic [BLOCK_W-1:0]   mem [DEPTH];

  // Tag bits alias and offset bits are handled by the requester.
  assign addr_unused = ^{req_addr[31:IDX_HI+1], req_addr[IDX_LO-1:0]};

  // Natural IDX_BITS-wide overflow gives the wrap from the last line to line 0.
  assign idx_next  = idx_q + IDX_BITS'(1);
  assign do_access = (state_q == WAIT) && (cnt_q == 8'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      rwrite_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      rwrite_q <= rwrite_d;
    end
  end

  // NOTE: the backing array has no reset; contents survive rst_n, and a write
  // dropped by reset never reaches it because it only commits at the access edge.
  always_ff @(posedge clk) begin
    if (do_access && wr_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // NOTE: every next-state signal defaults to its current value first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    rwrite_d = rwrite_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d   = req_addr[IDX_HI:IDX_LO];
          wr_d    = req_write;
          wdata_d = req_wdata;
          cnt_d   = LAT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          rwrite_d = wr_q;
          if (wr_q) begin
            rdata0_d = wdata_q;
            rdata1_d = '0;
          end else begin
            rdata0_d = mem[idx_q];
            rdata1_d = mem[idx_next];
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RESP: begin
        // Returning to IDLE here means a new request is only seen next cycle.
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    busy       = (state_q != IDLE);
    resp_data0 = rdata0_q;
    resp_data1 = rdata1_q;
    resp_write = rwrite_q;
  end

endmodule

// File: tb/tb_line_fill_responder.sv
// Self-checking bench for line_fill_responder: directed table, multi-cycle
// corner sequences and a randomized run against a line-array reference model.
module tb_line_fill_responder;

  localparam int BW  = 256;
  localparam int LAT = 4;

  localparam logic [BW-1:0] LINE_A   = {8{32'hA5A5_0003}};
  localparam logic [BW-1:0] LINE_B   = {8{32'hB6B6_0004}};
  localparam logic [BW-1:0] LINE_C   = {8{32'hC3C3_0002}};
  localparam logic [BW-1:0] LINE_P0  = {8{32'h0F0F_0000}};
  localparam logic [BW-1:0] LINE_P1  = {8{32'h1E1E_0001}};
  localparam logic [BW-1:0] LINE_P63 = {8{32'h6363_003F}};
  localparam logic [BW-1:0] LINE_Q63 = {4{64'hDEAD_BEEF_0000_003F}};
  localparam logic [BW-1:0] LINE_E   = {8{32'hEEEE_0005}};
  localparam logic [BW-1:0] LINE_F   = {8{32'hFFFF_0006}};
  localparam logic [BW-1:0] LINE_D   = {8{32'hDDDD_0005}};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = '0;
  logic          req_write = 1'b0;
  logic [BW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [BW-1:0] resp_data0;
  logic [BW-1:0] resp_data1;
  logic          resp_write;
  logic          busy;

  int n_checks = 0;
  int n_fail   = 0;

  line_fill_responder #(
    .BLOCK_W (BW),
    .OFF_BITS(5),
    .IDX_BITS(6),
    .MISS_LAT(LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_write (req_write),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data0(resp_data0),
    .resp_data1(resp_data1),
    .resp_write(resp_write),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] rand_line();
    logic [BW-1:0] v;
    for (int i = 0; i < BW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1'b1);
    check({tag, "_resp_valid"}, resp_valid, 1'b0);
    check({tag, "_resp_write"}, resp_write, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_data0"}, resp_data0, '0);
    check({tag, "_data1"}, resp_data1, '0);
  endtask

  // One full transaction; while holding the response it toggles req_valid
  // with junk requests, which must neither be accepted nor disturb outputs.
  task automatic do_req(input bit wr, input logic [31:0] addr, input logic [BW-1:0] wd,
                        input int hold, output logic [BW-1:0] d0, output logic [BW-1:0] d1,
                        output logic w, output int lat);
    d0 = '0; d1 = '0; w = 1'b0;
    @(posedge clk); #1;
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = rand_line();
    check("accepted_busy", busy, 1'b1);
    check("accepted_not_ready", req_ready, 1'b0);
    lat = 0;
    while (!resp_valid && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    check("resp_arrived", resp_valid, 1'b1);
    if (!resp_valid) return;
    d0 = resp_data0; d1 = resp_data1; w = resp_write;
    for (int i = 0; i < hold; i++) begin
      req_valid = i[0]; req_write = ~wr; req_addr = $urandom; req_wdata = rand_line();
      @(posedge clk); #1;
      check("hold_valid", resp_valid, 1'b1);
      check("hold_not_ready", req_ready, 1'b0);
      check("hold_data0", resp_data0, d0);
      check("hold_data1", resp_data1, d1);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("handshake_drop", resp_valid, 1'b0);
    check("handshake_idle", busy, 1'b0);
  endtask

  typedef struct {
    bit            wr;
    logic [31:0]   addr;
    logic [BW-1:0] wdata;
    logic [BW-1:0] e0;
    logic [BW-1:0] e1;
    bit            ew;
  } vec_t;

  logic [BW-1:0] mem_m [64];

  initial begin
    vec_t          tbl [10];
    logic [BW-1:0] d0, d1, wd;
    logic          w;
    int            lat;
    logic [31:0]   addr;
    int            idx;
    bit            wr;

    tbl[0] = '{1'b1, 32'h0000_07E0, LINE_P63, LINE_P63, '0, 1'b1};
    tbl[1] = '{1'b1, 32'h0000_0000, LINE_P0,  LINE_P0,  '0, 1'b1};
    tbl[2] = '{1'b0, 32'h0000_07E0, '0,       LINE_P63, LINE_P0, 1'b0};
    tbl[3] = '{1'b1, 32'h0000_0020, LINE_P1,  LINE_P1,  '0, 1'b1};
    tbl[4] = '{1'b1, 32'h0000_0040, LINE_C,   LINE_C,   '0, 1'b1};
    tbl[5] = '{1'b0, 32'h0000_0020, '0,       LINE_P1,  LINE_C, 1'b0};
    tbl[6] = '{1'b0, 32'h1234_5060, '0,       LINE_A,   LINE_B, 1'b0};
    tbl[7] = '{1'b0, 32'h0000_007F, '0,       LINE_A,   LINE_B, 1'b0};
    tbl[8] = '{1'b1, 32'hFFFF_FFE0, LINE_Q63, LINE_Q63, '0, 1'b1};
    tbl[9] = '{1'b0, 32'h0000_07E0, '0,       LINE_Q63, LINE_P0, 1'b0};

    // Reset state, checked while reset is still asserted.
    #3;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Preload lines 3 and 4, reset again: the array must keep its contents.
    do_req(1'b1, 32'h0000_0060, LINE_A, 0, d0, d1, w, lat);
    do_req(1'b1, 32'h0000_0080, LINE_B, 0, d0, d1, w, lat);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_reset_outputs("rst2");
    @(posedge clk); #1 rst_n = 1'b1;
    do_req(1'b0, 32'h0000_0060, '0, 0, d0, d1, w, lat);
    check("pre_latency", lat, LAT);
    check("pre_data0", d0, LINE_A);
    check("pre_data1", d1, LINE_B);
    check("pre_write", w, 1'b0);

    for (int i = 0; i < 10; i++) begin
      do_req(tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1, d0, d1, w, lat);
      check($sformatf("tbl%0d_latency", i), lat, LAT);
      check($sformatf("tbl%0d_data0", i), d0, tbl[i].e0);
      check($sformatf("tbl%0d_data1", i), d1, tbl[i].e1);
      check($sformatf("tbl%0d_write", i), w, tbl[i].ew);
    end

    // Long stall in RESP with req_valid toggling; then confirm nothing was queued.
    do_req(1'b0, 32'h0000_0060, '0, 10, d0, d1, w, lat);
    check("stall_data0", d0, LINE_A);
    check("stall_data1", d1, LINE_B);
    repeat (2) begin
      @(posedge clk); #1;
      check("stall_no_ghost", busy, 1'b0);
    end

    // Reset two cycles into WAIT of a write to line 5: write must be dropped.
    do_req(1'b1, 32'h0000_00A0, LINE_E, 0, d0, d1, w, lat);
    do_req(1'b1, 32'h0000_00C0, LINE_F, 0, d0, d1, w, lat);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_00A0; req_wdata = LINE_D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("midwait_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1 check_reset_outputs("midwait");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("midwait_no_resp", resp_valid, 1'b0);
    end
    do_req(1'b0, 32'h0000_00A0, '0, 0, d0, d1, w, lat);
    check("midwait_old0", d0, LINE_E);
    check("midwait_old1", d1, LINE_F);

    // Randomized phase against a plain line-array model.
    for (int i = 0; i < 64; i++) begin
      mem_m[i] = rand_line();
      do_req(1'b1, {$urandom_range(0, 2**21 - 1), 6'(i), 5'($urandom)}, mem_m[i], 0, d0, d1, w, lat);
    end
    for (int n = 0; n < 200; n++) begin
      wr   = ($urandom_range(0, 2) == 0);
      addr = $urandom;
      idx  = int'(addr[10:5]);
      wd   = rand_line();
      do_req(wr, addr, wd, $urandom_range(0, 3), d0, d1, w, lat);
      check("rnd_latency", lat, LAT);
      check("rnd_write", w, wr);
      if (wr) begin
        mem_m[idx] = wd;
        check("rnd_wdata0", d0, wd);
        check("rnd_wdata1", d1, '0);
      end else begin
        check("rnd_rdata0", d0, mem_m[idx]);
        check("rnd_rdata1", d1, mem_m[(idx + 1) % 64]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
